// File: rtl/tm1638_pattern_gen_pkg.sv
// Types and constants for the TM1638 test-pattern source.
package tm1638_pattern_gen_types;

  typedef enum logic [1:0] {
    ROUND_ROBIN = 2'd0,
    WALK        = 2'd1,
    HEX_COUNT   = 2'd2,
    HOLD        = 2'd3
  } pattern_mode_t;

  typedef enum logic {
    WAIT    = 1'b0,
    PRESENT = 1'b1
  } pg_state_t;

  localparam int DELAY_WIDTH = 24;

  // Seven-segment glyphs 0..F, decimal point (bit 7) off.
  localparam logic [7:0] HEX_FONT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/tm1638_types.sv
// Shared TM1638 display types: per-grid segment frame, LED row and grid index.
package tm1638_types;

  localparam int MAX_GRIDS = 8;

  typedef logic [MAX_GRIDS-1:0][7:0]      segments_t;  // [grid][segment]
  typedef logic [7:0]                     leds_t;
  typedef logic [$clog2(MAX_GRIDS)-1:0]   grid_t;

endpackage

// File: rtl/tm1638_hex_font.sv
// Combinational nibble to seven-segment glyph lookup.
module tm1638_hex_font
  import tm1638_pattern_gen_types::*;
(
  input  logic [3:0] i_Nibble,
  output logic [7:0] o_Segments
);

  assign o_Segments = HEX_FONT[i_Nibble];

endmodule

// File: rtl/tm1638_pattern_gen.sv
// Multi-mode TM1638 test-pattern source with valid/ready output and programmable update rate.
// Optional brightness sequencer enabled by TM1638_PATTERN_GEN_BRIGHTNESS_EN.
module tm1638_pattern_gen
  import tm1638_types::*;
  import tm1638_pattern_gen_types::*;
#(
  parameter int NUM_GRIDS   = 8,
  parameter int STEP_DELAY  = 0,
  parameter int COUNT_WIDTH = 32
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [1:0] i_Mode,
  input  logic       i_Ready,
  output segments_t  o_Segments,
  output leds_t      o_Leds,
`ifdef TM1638_PATTERN_GEN_BRIGHTNESS_EN
  output logic [2:0] o_Brightness,
`endif
  output logic       o_Valid
);

  localparam logic [DELAY_WIDTH-1:0] STEP_LIMIT = DELAY_WIDTH'(STEP_DELAY);
  localparam grid_t                  LAST_GRID  = grid_t'(NUM_GRIDS - 1);
  localparam int                     DIGIT_BITS = 4 * NUM_GRIDS;

  pg_state_t              state, nx_state;
  logic [DELAY_WIDTH-1:0] delay_cnt, nx_delay_cnt;
  grid_t                  grid, nx_grid;
  logic [2:0]             bit_idx, nx_bit_idx;
  logic [7:0]             pattern, nx_pattern;
  logic [COUNT_WIDTH-1:0] count, nx_count;
  pattern_mode_t          last_mode, nx_last_mode;
  segments_t              nx_segments;
  leds_t                  nx_leds;
  logic                   nx_valid;
`ifdef TM1638_PATTERN_GEN_BRIGHTNESS_EN
  logic [2:0]             nx_brightness;
`endif

  pattern_mode_t          mode;
  logic                   mode_change;
  segments_t              base_segments;
  grid_t                  base_grid;
  logic [2:0]             base_bit;
  logic [7:0]             base_pattern;
  logic [COUNT_WIDTH-1:0] base_count;
  segments_t              font_segments;

  // A mode change restarts the pattern from a blank frame within the same update.
  assign mode          = pattern_mode_t'(i_Mode);
  assign mode_change   = (mode != last_mode);
  assign base_segments = mode_change ? '0 : o_Segments;
  assign base_grid     = mode_change ? '0 : grid;
  assign base_bit      = mode_change ? '0 : bit_idx;
  assign base_pattern  = mode_change ? '0 : pattern;
  assign base_count    = mode_change ? '0 : count;

  // Grid 0 carries the most significant nibble.
  for (genvar g = 0; g < MAX_GRIDS; g++) begin : g_font
    if (g < NUM_GRIDS) begin : g_active
      tm1638_hex_font u_font (
        .i_Nibble   (base_count[4*(NUM_GRIDS-1-g) +: 4]),
        .o_Segments (font_segments[g])
      );
    end else begin : g_blank
      assign font_segments[g] = 8'h00;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    nx_state     = state;
    nx_delay_cnt = delay_cnt;
    nx_grid      = grid;
    nx_bit_idx   = bit_idx;
    nx_pattern   = pattern;
    nx_count     = count;
    nx_last_mode = last_mode;
    nx_segments  = o_Segments;
    nx_leds      = o_Leds;
    nx_valid     = o_Valid;
`ifdef TM1638_PATTERN_GEN_BRIGHTNESS_EN
    nx_brightness = o_Brightness;
`endif

    unique case (state)
      WAIT: begin
        if (delay_cnt != STEP_LIMIT) begin
          nx_delay_cnt = delay_cnt + DELAY_WIDTH'(1);
        end else if (mode != HOLD) begin
          nx_state     = PRESENT;
          nx_valid     = 1'b1;
          nx_last_mode = mode;
          nx_grid      = base_grid;
          nx_bit_idx   = base_bit;
          nx_pattern   = base_pattern;
          nx_count     = base_count;
          unique case (mode)
            ROUND_ROBIN: begin
              nx_segments            = base_segments;
              nx_segments[base_grid] = base_pattern;
              nx_leds                = o_Leds + 8'd1;
              if (base_grid == LAST_GRID) begin
                nx_grid    = '0;
                nx_pattern = base_pattern + 8'd1;
`ifdef TM1638_PATTERN_GEN_BRIGHTNESS_EN
                nx_brightness = o_Brightness + 3'd1;
`endif
              end else begin
                nx_grid = base_grid + grid_t'(1);
              end
            end
            WALK: begin
              nx_segments            = '0;
              nx_segments[base_grid] = 8'd1 << base_bit;
              nx_leds                = 8'd1 << base_grid;
              nx_bit_idx             = base_bit + 3'd1;
              if (base_bit == 3'd7) begin
                if (base_grid == LAST_GRID) begin
                  nx_grid = '0;
`ifdef TM1638_PATTERN_GEN_BRIGHTNESS_EN
                  nx_brightness = o_Brightness + 3'd1;
`endif
                end else begin
                  nx_grid = base_grid + grid_t'(1);
                end
              end
            end
            HEX_COUNT: begin
              nx_segments = font_segments;
              nx_leds     = leds_t'(base_count);
              nx_count    = base_count + COUNT_WIDTH'(1);
`ifdef TM1638_PATTERN_GEN_BRIGHTNESS_EN
              if (&base_count[DIGIT_BITS-1:0]) nx_brightness = o_Brightness + 3'd1;
`endif
            end
            default: ;
          endcase
        end
      end
      PRESENT: begin
        if (i_Ready) begin
          nx_state     = WAIT;
          nx_valid     = 1'b0;
          nx_delay_cnt = '0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= WAIT;
      delay_cnt  <= '0;
      grid       <= '0;
      bit_idx    <= '0;
      pattern    <= '0;
      count      <= '0;
      last_mode  <= ROUND_ROBIN;
      o_Segments <= '0;
      o_Leds     <= '0;
      o_Valid    <= 1'b0;
`ifdef TM1638_PATTERN_GEN_BRIGHTNESS_EN
      o_Brightness <= '0;
`endif
    end else begin
      state      <= nx_state;
      delay_cnt  <= nx_delay_cnt;
      grid       <= nx_grid;
      bit_idx    <= nx_bit_idx;
      pattern    <= nx_pattern;
      count      <= nx_count;
      last_mode  <= nx_last_mode;
      o_Segments <= nx_segments;
      o_Leds     <= nx_leds;
      o_Valid    <= nx_valid;
`ifdef TM1638_PATTERN_GEN_BRIGHTNESS_EN
      o_Brightness <= nx_brightness;
`endif
    end
  end

endmodule
